// File: rtl/buzzer_sequencer.sv
// Buzzer request sequencer.
// Turns keypress and cook-done events into one-cycle beep requests for a
// downstream buzzer. It spaces requests by a full tone slot, queues one key
// and one alarm, and repeats the completion alarm up to ALARM_REPEAT times.
module buzzer_sequencer #(
  parameter int BEEP_SLOT    = 12_000_000,
  parameter int ALARM_SLOT   = 110_000_000,
  parameter int ALARM_REPEAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic key_event,
  input  logic done_event,
  input  logic mute,
  output logic button_pressed,
  output logic completion_alarm,
  output logic busy,
  output logic alarm_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY   = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [26:0] BEEP_LAST   = 27'(BEEP_SLOT - 1);
  localparam logic [26:0] ALARM_LAST  = 27'(ALARM_SLOT - 1);
  localparam logic [1:0]  REPEAT_LOAD = 2'(ALARM_REPEAT - 1);

  state_t      state;
  logic [26:0] slot_cnt;
  logic [1:0]  beeps_left;
  logic        key_pend;
  logic        alarm_pend;
  // Low for the first edge after reset release, so events arriving
  // together with the release are not taken.
  logic        armed;

  logic        key_ok;
  logic        done_ok;
  logic [1:0]  beeps_eff;

  assign key_ok  = key_event  && !mute && armed;
  assign done_ok = done_event && !mute && armed;

  // Repeat count as modified by this cycle's events while alarming:
  // a new done re-arms the full repeat count and beats a simultaneous key,
  // a key alone silences the remaining repeats.
  always_comb begin
    beeps_eff = beeps_left;
    if (key_ok)  beeps_eff = 2'd0;
    if (done_ok) beeps_eff = REPEAT_LOAD;
  end

  // Sequencer FSM with registered request pulses and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      slot_cnt         <= '0;
      beeps_left       <= '0;
      key_pend         <= 1'b0;
      alarm_pend       <= 1'b0;
      armed            <= 1'b0;
      button_pressed   <= 1'b0;
      completion_alarm <= 1'b0;
      busy             <= 1'b0;
      alarm_active     <= 1'b0;
    end else begin
      armed            <= 1'b1;
      button_pressed   <= 1'b0;
      completion_alarm <= 1'b0;
      case (state)
        IDLE: begin
          if (done_ok || alarm_pend) begin
            // Alarm wins; a coincident key is held for after the alarm.
            completion_alarm <= !mute;
            beeps_left       <= REPEAT_LOAD;
            slot_cnt         <= '0;
            alarm_pend       <= 1'b0;
            if (key_ok) key_pend <= 1'b1;
            state            <= ALARM;
            busy             <= 1'b1;
            alarm_active     <= 1'b1;
          end else if (key_ok || key_pend) begin
            button_pressed <= !mute;
            slot_cnt       <= '0;
            key_pend       <= 1'b0;
            state          <= KEY;
            busy           <= 1'b1;
          end
        end
        KEY: begin
          if (key_ok)  key_pend   <= 1'b1;
          if (done_ok) alarm_pend <= 1'b1;
          if (slot_cnt == BEEP_LAST) begin
            slot_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            slot_cnt <= slot_cnt + 27'd1;
          end
        end
        ALARM: begin
          if (slot_cnt == ALARM_LAST) begin
            slot_cnt <= '0;
            if (beeps_eff != 2'd0) begin
              completion_alarm <= !mute;
              beeps_left       <= beeps_eff - 2'd1;
            end else begin
              beeps_left   <= 2'd0;
              state        <= IDLE;
              busy         <= 1'b0;
              alarm_active <= 1'b0;
            end
          end else begin
            slot_cnt   <= slot_cnt + 27'd1;
            beeps_left <= beeps_eff;
          end
        end
        default: begin
          state        <= IDLE;
          slot_cnt     <= '0;
          busy         <= 1'b0;
          alarm_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: directed timing scenarios plus randomized
// traffic compared every cycle against a time-stamp based reference model.
module tb_buzzer_sequencer;

  localparam int BS  = 10;
  localparam int AS  = 20;
  localparam int REP = 3;

  logic clk;
  logic reset;
  logic key_event;
  logic done_event;
  logic mute;
  logic button_pressed;
  logic completion_alarm;
  logic busy;
  logic alarm_active;

  buzzer_sequencer #(
    .BEEP_SLOT   (BS),
    .ALARM_SLOT  (AS),
    .ALARM_REPEAT(REP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .key_event       (key_event),
    .done_event      (done_event),
    .mute            (mute),
    .button_pressed  (button_pressed),
    .completion_alarm(completion_alarm),
    .busy            (busy),
    .alarm_active    (alarm_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tracks which tone is sounding and the time it began,
  // plus the one-deep key and alarm queues.
  bit m_in_key, m_in_alarm, m_kq, m_aq, m_armed;
  int m_t, m_start, m_reps;
  bit e_bp, e_ca;

  // Scenario recording
  int           cyc;
  bit           prev_pulse;
  logic [127:0] bp_m, ca_m, busy_m, aa_m;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [127:0] bit_at(input int c);
    return 128'd1 << c;
  endfunction

  function automatic logic [127:0] rng(input int lo, input int hi);
    return (128'd1 << (hi + 1)) - (128'd1 << lo);
  endfunction

  task automatic model_reset();
    m_in_key = 0; m_in_alarm = 0; m_kq = 0; m_aq = 0; m_armed = 0;
    m_t = 0; m_start = 0; m_reps = 0; e_bp = 0; e_ca = 0;
  endtask

  task automatic model_step(input bit ki, input bit di, input bit mi);
    bit k, d;
    int eff;
    k = ki && !mi && m_armed;
    d = di && !mi && m_armed;
    m_armed = 1;
    m_t++;
    e_bp = 0;
    e_ca = 0;
    if (!m_in_key && !m_in_alarm) begin
      if (d || m_aq) begin
        e_ca = !mi; m_in_alarm = 1; m_start = m_t; m_reps = REP - 1; m_aq = 0;
        if (k) m_kq = 1;
      end else if (k || m_kq) begin
        e_bp = !mi; m_in_key = 1; m_start = m_t; m_kq = 0;
      end
    end else if (m_in_key) begin
      if (k) m_kq = 1;
      if (d) m_aq = 1;
      if (m_t - m_start == BS) m_in_key = 0;
    end else begin
      eff = d ? REP - 1 : (k ? 0 : m_reps);
      if (m_t - m_start == AS) begin
        if (eff > 0) begin
          e_ca = !mi; m_reps = eff - 1; m_start = m_t;
        end else begin
          m_in_alarm = 0;
        end
      end else begin
        m_reps = eff;
      end
    end
  endtask

  // Drive one cycle's inputs (called at a falling edge), then compare.
  task automatic run_cycle(input bit k, input bit d, input bit m);
    key_event = k; done_event = d; mute = m;
    @(posedge clk);
    model_step(k, d, m);
    @(negedge clk);
    cyc++;
    check("outputs", {button_pressed, completion_alarm, busy, alarm_active},
          {e_bp, e_ca, m_in_key | m_in_alarm, m_in_alarm});
    check("pulse_rule",
          {button_pressed & completion_alarm,
           (button_pressed | completion_alarm) & prev_pulse}, 0);
    prev_pulse = button_pressed | completion_alarm;
    if (cyc < 128) begin
      bp_m[cyc]   = button_pressed;
      ca_m[cyc]   = completion_alarm;
      busy_m[cyc] = busy;
      aa_m[cyc]   = alarm_active;
    end
  endtask

  task automatic clear_rec();
    cyc = 0; bp_m = '0; ca_m = '0; busy_m = '0; aa_m = '0;
  endtask

  // Assert reset at a falling edge, hold two cycles, release with both
  // events high on the release cycle, then settle for two idle cycles.
  task automatic apply_reset();
    reset = 1'b0; key_event = 0; done_event = 0; mute = 0;
    #1;
    check("reset_outputs", {button_pressed, completion_alarm, busy, alarm_active}, 0);
    model_reset();
    prev_pulse = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_cycle(1, 1, 0);
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 0);
  endtask

  task automatic run_scen(input int len, input logic [127:0] km,
                          input logic [127:0] dm, input logic [127:0] mm);
    apply_reset();
    clear_rec();
    for (int c = 0; c < len; c++) run_cycle(km[c], dm[c], mm[c]);
    key_event = 0; done_event = 0; mute = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; key_event = 0; done_event = 0; mute = 0;
    model_reset();
    clear_rec();
    prev_pulse = 0;
    @(negedge clk);

    // Reset release with coincident events: nothing happens.
    apply_reset();
    check("release_ignored", {button_pressed, completion_alarm, busy}, 0);

    // Single key
    run_scen(30, bit_at(5), 0, 0);
    check("k1_bp", bp_m, bit_at(6));
    check("k1_ca", ca_m, 0);
    check("k1_busy", busy_m, rng(6, 15));

    // Done: three alarm beeps
    run_scen(80, 0, bit_at(0), 0);
    check("d1_ca", ca_m, bit_at(1) | bit_at(21) | bit_at(41));
    check("d1_bp", bp_m, 0);
    check("d1_aa", aa_m, rng(1, 60));
    check("d1_busy", busy_m, rng(1, 60));

    // Key queue one deep
    run_scen(40, bit_at(5) | bit_at(8) | bit_at(9) | bit_at(10), 0, 0);
    check("kq_bp", bp_m, bit_at(6) | bit_at(17));
    check("kq_busy", busy_m, rng(6, 15) | rng(17, 26));

    // Key during alarm silences remaining repeats
    run_scen(60, bit_at(25), bit_at(0), 0);
    check("ka_ca", ca_m, bit_at(1) | bit_at(21));
    check("ka_busy", busy_m, rng(1, 40));

    // Done during key beep is queued
    run_scen(90, bit_at(0), bit_at(3), 0);
    check("dk_bp", bp_m, bit_at(1));
    check("dk_ca", ca_m, bit_at(12) | bit_at(32) | bit_at(52));
    check("dk_busy", busy_m, rng(1, 10) | rng(12, 71));

    // Simultaneous key and done in idle: alarm first, key afterwards
    run_scen(90, bit_at(0), bit_at(0), 0);
    check("kd_ca", ca_m, bit_at(1) | bit_at(21) | bit_at(41));
    check("kd_bp", bp_m, bit_at(62));
    check("kd_busy", busy_m, rng(1, 60) | rng(62, 71));

    // Mute suppresses pulses and events but not timing
    run_scen(90, bit_at(70), bit_at(0), rng(10, 50) | bit_at(70));
    check("mu_ca", ca_m, bit_at(1));
    check("mu_bp", bp_m, 0);
    check("mu_aa", aa_m, rng(1, 60));

    // Done reload in alarm beats a coincident key
    run_scen(110, bit_at(30), bit_at(0) | bit_at(30), 0);
    check("rl_ca", ca_m, bit_at(1) | bit_at(21) | bit_at(41) | bit_at(61));
    check("rl_aa", aa_m, rng(1, 80));

    // Reset mid-alarm aborts the sequence
    run_scen(30, 0, bit_at(0), 0);
    check("ra_active", {alarm_active, busy}, 2'b11);
    apply_reset();
    clear_rec();
    for (int c = 0; c < 60; c++) run_cycle(0, 0, 0);
    check("ra_bp", bp_m, 0);
    check("ra_ca", ca_m, 0);
    check("ra_busy", busy_m, 0);
    run_cycle(1, 0, 0);
    run_cycle(0, 0, 0);
    check("ra_new", bp_m, bit_at(61));

    // Randomized traffic against the model
    apply_reset();
    begin
      bit m;
      m = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 999) == 0) apply_reset();
        if ($urandom_range(0, 49) == 0) m = !m;
        run_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, m);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
